// File: rtl/uart_pkg.sv
// Shared UART framing constants and the transmit state encoding.
// No logic; imported by the transmitter and its byte serializer.
package uart_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_FRAME_BITS = 10;
  localparam logic UART_START_BIT = 1'b0;
  localparam logic UART_STOP_BIT  = 1'b1;

  localparam logic [2:0] TX_IDLE  = 3'd0;
  localparam logic [2:0] TX_START = 3'd1;
  localparam logic [2:0] TX_DATA  = 3'd2;
  localparam logic [2:0] TX_STOP  = 3'd3;
  localparam logic [2:0] TX_GAP   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = TX_IDLE,
    S_START = TX_START,
    S_DATA  = TX_DATA,
    S_STOP  = TX_STOP,
    S_GAP   = TX_GAP
  } tx_state_t;

endpackage

// File: rtl/uart_tx_byte_ser.sv
// One-byte serializer: start, 8 data bits LSB first, stop, GAP_BITS idle; 10+GAP_BITS cycles.
// Latency 1 cycle from load to start bit; empty is high in idle and in the final bit, so a load then chains with no dead cycle.
module uart_tx_byte_ser
  import uart_pkg::*;
#(
  parameter int GAP_BITS = 1
) (
  input  logic       txclk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] byte_in,
  output logic       empty,
  output logic       tx_out
);

  localparam logic [2:0] GAP_LAST = (GAP_BITS == 0) ? 3'd0 : 3'(GAP_BITS - 1);

  tx_state_t                 state;
  logic [2:0]                bit_cnt;
  logic [2:0]                gap_cnt;
  logic [UART_DATA_BITS-1:0] shreg;
  logic                      last_bit;

  always_comb begin
    last_bit = 1'b0;
    if (GAP_BITS == 0)
      last_bit = (state == S_STOP);
    else
      last_bit = (state == S_GAP) && (gap_cnt == GAP_LAST);
  end

  assign empty = (state == S_IDLE) || last_bit;

  always_ff @(posedge txclk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      tx_out  <= UART_STOP_BIT;
      bit_cnt <= '0;
      gap_cnt <= '0;
      shreg   <= '0;
    end else if (empty) begin
      // Last bit of a byte doubles as the load slot for the next one.
      if (load) begin
        state  <= S_START;
        tx_out <= UART_START_BIT;
        shreg  <= byte_in;
      end else begin
        state  <= S_IDLE;
        tx_out <= UART_STOP_BIT;
      end
    end else begin
      unique case (state)
        S_START: begin
          state   <= S_DATA;
          tx_out  <= shreg[0];
          shreg   <= shreg >> 1;
          bit_cnt <= '0;
        end
        S_DATA: begin
          if (bit_cnt == 3'd7) begin
            state  <= S_STOP;
            tx_out <= UART_STOP_BIT;
          end else begin
            tx_out  <= shreg[0];
            shreg   <= shreg >> 1;
            bit_cnt <= bit_cnt + 3'd1;
          end
        end
        S_STOP: begin
          state   <= S_GAP;
          gap_cnt <= '0;
          tx_out  <= UART_STOP_BIT;
        end
        S_GAP: begin
          gap_cnt <= gap_cnt + 3'd1;
          tx_out  <= UART_STOP_BIT;
        end
        default: begin
          state  <= S_IDLE;
          tx_out <= UART_STOP_BIT;
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_framed.sv
// Word-framed UART TX: NBYTES data bytes MSB-byte first plus a trailer (XOR checksum when UART_TX_CHKSUM_EN is defined).
// Latency: start bit 1 cycle after accept, done at accept+1+(NBYTES+1)*(10+GAP_BITS); words offered while busy are dropped.
module uart_tx_framed
  import uart_pkg::*;
#(
  parameter int         NBYTES   = 4,
  parameter logic [7:0] TRAILER  = 8'h0A,
  parameter int         GAP_BITS = 1
) (
  input  logic                txclk,
  input  logic                reset,
  input  logic                word_valid,
  input  logic [8*NBYTES-1:0] word_data,
  output logic                word_ready,
  output logic                tx_out,
  output logic                busy,
  output logic                done
);

  localparam int W  = 8 * NBYTES;
  localparam int CW = $clog2(NBYTES + 2);
  localparam logic [CW-1:0] DATA_CNT = CW'(NBYTES);
  localparam logic [CW-1:0] LAST_CNT = CW'(NBYTES + 1);

  logic [W-1:0]  word_q;
  logic [CW-1:0] bytes_sent;
  logic [7:0]    trailer_q;
  logic [7:0]    trailer_next;
  logic [7:0]    ser_byte;
  logic          ser_empty;
  logic          ser_load;
  logic          accept;
  logic          finish;

`ifdef UART_TX_CHKSUM_EN
  function automatic logic [7:0] xor_bytes(input logic [W-1:0] w);
    logic [7:0] x;
    x = '0;
    for (int i = 0; i < NBYTES; i++) x = x ^ w[8*i +: 8];
    return x;
  endfunction

  logic unused_trailer;
  assign unused_trailer = ^TRAILER;
  assign trailer_next   = xor_bytes(word_data);
`else
  assign trailer_next = TRAILER;
`endif

  assign accept   = word_valid && word_ready;
  assign ser_load = busy && ser_empty && (bytes_sent != LAST_CNT);
  assign finish   = busy && ser_empty && (bytes_sent == LAST_CNT);
  assign ser_byte = (bytes_sent < DATA_CNT) ? word_q[W-1 -: 8] : trailer_q;

  always_ff @(posedge txclk or posedge reset) begin
    if (reset) begin
      word_ready <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      word_q     <= '0;
      bytes_sent <= '0;
      trailer_q  <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        word_q     <= word_data;
        trailer_q  <= trailer_next;
        bytes_sent <= '0;
        word_ready <= 1'b0;
        busy       <= 1'b1;
      end else if (ser_load) begin
        bytes_sent <= bytes_sent + CW'(1);
        if (bytes_sent < DATA_CNT) word_q <= word_q << 8;
      end else if (finish) begin
        busy       <= 1'b0;
        word_ready <= 1'b1;
        done       <= 1'b1;
        bytes_sent <= '0;
      end
    end
  end

  uart_tx_byte_ser #(
    .GAP_BITS (GAP_BITS)
  ) u_ser (
    .txclk   (txclk),
    .reset   (reset),
    .load    (ser_load),
    .byte_in (ser_byte),
    .empty   (ser_empty),
    .tx_out  (tx_out)
  );

endmodule

// File: tb/tb_uart_tx_framed.sv
// Directed bench: default 4-byte instance and a 1-byte, zero-gap instance; line bits are sampled on the falling edge.
module tb_uart_tx_framed;

`ifdef UART_TX_CHKSUM_EN
  localparam logic [7:0] TR_DEADBEEF = 8'h22;
  localparam logic [7:0] TR_0001     = 8'h01;
  localparam logic [7:0] TR_8000     = 8'h80;
  localparam logic [7:0] TR_A5       = 8'h00;
  localparam logic [7:0] TR_FF       = 8'hFF;
`else
  localparam logic [7:0] TR_DEADBEEF = 8'h0A;
  localparam logic [7:0] TR_0001     = 8'h0A;
  localparam logic [7:0] TR_8000     = 8'h0A;
  localparam logic [7:0] TR_A5       = 8'h0A;
  localparam logic [7:0] TR_FF       = 8'h0A;
`endif

  logic        txclk = 1'b0;
  logic        reset;
  logic        v0, v1;
  logic [31:0] d0;
  logic [7:0]  d1;
  logic        r0, tx0, b0, dn0;
  logic        r1, tx1, b1, dn1;
  logic        sel = 1'b0;
  logic        rdys, txs, bsys, dns;
  int          n_cmp = 0;
  int          n_fail = 0;

  always #5 txclk = ~txclk;

  uart_tx_framed dut (
    .txclk(txclk), .reset(reset), .word_valid(v0), .word_data(d0),
    .word_ready(r0), .tx_out(tx0), .busy(b0), .done(dn0)
  );

  uart_tx_framed #(.NBYTES(1), .TRAILER(8'h0A), .GAP_BITS(0)) dut1 (
    .txclk(txclk), .reset(reset), .word_valid(v1), .word_data(d1),
    .word_ready(r1), .tx_out(tx1), .busy(b1), .done(dn1)
  );

  assign rdys = sel ? r1  : r0;
  assign txs  = sel ? tx1 : tx0;
  assign bsys = sel ? b1  : b0;
  assign dns  = sel ? dn1 : dn0;

  // Expected line: idle 1s, with nb byte frames starting at sample index off.
  function automatic logic [127:0] frame_vec(input logic [47:0] seq, input int nb,
                                             input int gap, input int off);
    logic [127:0] v;
    logic [7:0]   b;
    int fl, k, p;
    v  = '1;
    fl = 10 + gap;
    for (int n = 0; n < 128; n++) begin
      if (n >= off && n < off + nb * fl) begin
        k = (n - off) / fl;
        p = (n - off) % fl;
        b = seq[(nb-1-k)*8 +: 8];
        if (p == 0)      v[n] = 1'b0;
        else if (p <= 8) v[n] = b[p-1];
        else             v[n] = 1'b1;
      end
    end
    return v;
  endfunction

  // Offer a word when the selected DUT is ready; returns at the falling edge after acceptance (sample n=0).
  task automatic go(input logic s, input logic [31:0] w, input logic hold);
    sel = s;
    @(negedge txclk);
    for (int i = 0; i < 200 && rdys !== 1'b1; i++) @(negedge txclk);
    n_cmp++;
    if (rdys !== 1'b1) begin
      n_fail++;
      $display("FAIL go_ready_timeout got=%b want=1", rdys);
    end
    if (s) begin v1 = 1'b1; d1 = w[7:0]; end
    else   begin v0 = 1'b1; d0 = w;      end
    @(negedge txclk);
    if (!hold) begin v0 = 1'b0; v1 = 1'b0; end
  endtask

  task automatic capture(input int ncyc, output logic [127:0] line, output logic [127:0] dv,
                         output logic [127:0] rv, output logic [127:0] bv);
    line = '1; dv = '0; rv = '0; bv = '0;
    for (int n = 0; n <= ncyc; n++) begin
      if (n > 0) @(negedge txclk);
      line[n] = txs; dv[n] = dns; rv[n] = rdys; bv[n] = bsys;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; v0 = 1'b0; v1 = 1'b0; d0 = '0; d1 = '0;
    repeat (2) @(negedge txclk);
    n_cmp += 4;
    if ({tx0, r0, b0, dn0} !== 4'b1100) begin
      n_fail++; $display("FAIL reset_dut {tx,ready,busy,done} got=%b want=1100", {tx0, r0, b0, dn0});
    end
    if (tx1 !== 1'b1) begin n_fail++; $display("FAIL reset_dut1_tx got=%b want=1", tx1); end
    if (r1 !== 1'b1)  begin n_fail++; $display("FAIL reset_dut1_ready got=%b want=1", r1); end
    if ({b1, dn1} !== 2'b00) begin n_fail++; $display("FAIL reset_dut1_busy_done got=%b want=00", {b1, dn1}); end
    reset = 1'b0;
    repeat (2) @(negedge txclk);
    n_cmp++;
    if ({tx0, r0, b0, dn0} !== 4'b1100) begin
      n_fail++; $display("FAIL post_reset_idle got=%b want=1100", {tx0, r0, b0, dn0});
    end
  endtask

  task automatic test_frame;
    logic [127:0] line, dv, rv, bv, exp;
    logic [9:0]   first;
    logic [7:0]   tr;
    go(1'b0, 32'hDEADBEEF, 1'b0);
    capture(60, line, dv, rv, bv);
    exp = frame_vec({8'hDE, 8'hAD, 8'hBE, 8'hEF, TR_DEADBEEF}, 5, 1, 1);
    for (int i = 0; i < 10; i++) first[9-i] = line[1+i];
    for (int i = 0; i < 8; i++) tr[i] = line[46+i];
    n_cmp += 7;
    if (line !== exp) begin n_fail++; $display("FAIL frame_line got=%h want=%h", line, exp); end
    if (first !== 10'b0011110111) begin n_fail++; $display("FAIL frame_first_byte got=%b want=0011110111", first); end
    if (tr !== TR_DEADBEEF) begin n_fail++; $display("FAIL frame_trailer got=%h want=%h", tr, TR_DEADBEEF); end
    if (dv !== (128'd1 << 56)) begin n_fail++; $display("FAIL frame_done got=%h want=%h", dv, 128'd1 << 56); end
    if ({rv[0], bv[0]} !== 2'b01) begin n_fail++; $display("FAIL accept_ready_busy got=%b want=01", {rv[0], bv[0]}); end
    if ({rv[56], bv[56]} !== 2'b10) begin n_fail++; $display("FAIL done_ready_busy got=%b want=10", {rv[56], bv[56]}); end
    if ({rv[55], bv[55]} !== 2'b01) begin n_fail++; $display("FAIL gap_ready_busy got=%b want=01", {rv[55], bv[55]}); end
  endtask

  task automatic test_back_to_back;
    logic [127:0] line, dv, rv, bv, exp;
    go(1'b0, 32'h00000001, 1'b1);
    d0 = 32'h80000000;
    fork
      capture(120, line, dv, rv, bv);
      begin
        repeat (57) @(negedge txclk);
        v0 = 1'b0;
      end
    join
    exp = frame_vec({8'h00, 8'h00, 8'h00, 8'h01, TR_0001}, 5, 1, 1)
        & frame_vec({8'h80, 8'h00, 8'h00, 8'h00, TR_8000}, 5, 1, 58);
    n_cmp += 3;
    if (line !== exp) begin n_fail++; $display("FAIL b2b_line got=%h want=%h", line, exp); end
    if (dv !== ((128'd1 << 56) | (128'd1 << 113))) begin
      n_fail++; $display("FAIL b2b_done got=%h want=%h", dv, (128'd1 << 56) | (128'd1 << 113));
    end
    if ({rv[56], rv[57], bv[57]} !== 3'b101) begin
      n_fail++; $display("FAIL b2b_reaccept got=%b want=101", {rv[56], rv[57], bv[57]});
    end
  endtask

  task automatic test_ignore_busy;
    logic [127:0] line, dv, rv, bv, exp;
    go(1'b0, 32'hDEADBEEF, 1'b0);
    fork
      capture(70, line, dv, rv, bv);
      begin
        repeat (19) @(negedge txclk);
        v0 = 1'b1; d0 = 32'h12345678;
        @(negedge txclk);
        v0 = 1'b0;
      end
    join
    exp = frame_vec({8'hDE, 8'hAD, 8'hBE, 8'hEF, TR_DEADBEEF}, 5, 1, 1);
    n_cmp += 3;
    if (line !== exp) begin n_fail++; $display("FAIL ignore_line got=%h want=%h", line, exp); end
    if (dv !== (128'd1 << 56)) begin n_fail++; $display("FAIL ignore_done got=%h want=%h", dv, 128'd1 << 56); end
    if ({rv[70], bv[70]} !== 2'b10) begin n_fail++; $display("FAIL ignore_idle_after got=%b want=10", {rv[70], bv[70]}); end
  endtask

  task automatic test_reset_mid_frame;
    logic [127:0] line, dv, rv, bv, exp;
    logic         quiet_bad;
    go(1'b0, 32'hDEADBEEF, 1'b0);
    repeat (30) @(negedge txclk);
    n_cmp++;
    if (tx0 !== 1'b0) begin n_fail++; $display("FAIL mid_data_bit got=%b want=0", tx0); end
    #1 reset = 1'b1;
    #1;
    n_cmp++;
    if ({tx0, r0, b0, dn0} !== 4'b1100) begin
      n_fail++; $display("FAIL async_reset got=%b want=1100", {tx0, r0, b0, dn0});
    end
    repeat (3) @(negedge txclk);
    reset = 1'b0;
    quiet_bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge txclk);
      if (tx0 !== 1'b1 || dn0 !== 1'b0) quiet_bad = 1'b1;
    end
    n_cmp++;
    if (quiet_bad !== 1'b0) begin n_fail++; $display("FAIL reset_quiet got=%b want=0", quiet_bad); end
    go(1'b0, 32'hA5A5A5A5, 1'b0);
    capture(60, line, dv, rv, bv);
    exp = frame_vec({8'hA5, 8'hA5, 8'hA5, 8'hA5, TR_A5}, 5, 1, 1);
    n_cmp += 2;
    if (line !== exp) begin n_fail++; $display("FAIL after_reset_line got=%h want=%h", line, exp); end
    if (dv !== (128'd1 << 56)) begin n_fail++; $display("FAIL after_reset_done got=%h want=%h", dv, 128'd1 << 56); end
  endtask

  task automatic test_nbytes1_nogap;
    logic [127:0] line, dv, rv, bv, exp;
    go(1'b1, 32'h000000FF, 1'b0);
    capture(30, line, dv, rv, bv);
    exp = frame_vec({8'hFF, TR_FF}, 2, 0, 1);
    n_cmp += 3;
    if (line !== exp) begin n_fail++; $display("FAIL nb1_line got=%h want=%h", line, exp); end
    if (dv !== (128'd1 << 21)) begin n_fail++; $display("FAIL nb1_done got=%h want=%h", dv, 128'd1 << 21); end
    if ({rv[21], bv[21], rv[20], bv[20]} !== 4'b1001) begin
      n_fail++; $display("FAIL nb1_ready_busy got=%b want=1001", {rv[21], bv[21], rv[20], bv[20]});
    end
    sel = 1'b0;
  endtask

  initial begin
    test_reset;
    test_frame;
    test_back_to_back;
    test_ignore_busy;
    test_reset_mid_frame;
    test_nbytes1_nogap;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
